uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among `NUM_REQ` byte-producing requesters. It arbitrates round-robin, latches the winner's byte, and drives `tx_in`/`tx_start` into `uart_transmitter`. It then follows `tx_busy` through the frame and acknowledges the requester once the transmitter has accepted the byte. It sits between the client logic and the `tx_in`/`tx_start`/`tx_busy` pins of `uart_transmitter` inside the `uart` top level.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is set.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the previous winner; search starts one above it
//   found      - at least one request bit is set
//   grant_idx  - index of the winning requester (0 when found=0)
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

    // One extra bit holds last_grant + k before the modulo fold, so
    // non-power-of-two NUM_REQ wraps correctly.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte requesters.
// Latency: grant registered one edge after req is seen in IDLE; ack one edge after tx_busy rises.
// Backpressure: holds tx_start until tx_busy; no grants while the transmitter is busy.
//
// Ports:
//   clk, rst_n   - clock shared with uart_transmitter; async active-low reset
//   req          - per-requester level-held byte-valid
//   req_data     - requester i byte on [8i+7:8i], latched at grant
//   ack          - one-cycle pulse to the requester whose byte was accepted
//   grant_id     - requester currently being served
//   arb_busy     - high whenever not IDLE
//   timeout_err  - one-cycle pulse when tx_busy never rose within START_TIMEOUT
//   tx_in, tx_start, tx_busy - handshake with uart_transmitter
//
// Build option: define UART_ARB_PRIO0_EN to give requester 0 absolute
// priority; the remaining requesters then round-robin among themselves.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic                        timeout_err,
    output logic [DATA_W-1:0]           tx_in,
    output logic                        tx_start,
    input  logic                        tx_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    uart_arb_state_t   state;
    logic [IDX_W-1:0]  last_grant;
    logic [CNT_W-1:0]  start_cnt;

    logic [DATA_W-1:0] req_bytes [NUM_REQ];

    logic [NUM_REQ-1:0] pick_req;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               win_upd_last;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (pick_req),
        .last_grant (last_grant),
        .found      (rr_found),
        .grant_idx  (rr_idx)
    );

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and does not move the pointer, so
    // the others keep their round-robin order across priority grants.
    always_comb begin
        pick_req     = {req[NUM_REQ-1:1], 1'b0};
        win_vld      = req[0] | rr_found;
        win_idx      = req[0] ? '0 : rr_idx;
        win_upd_last = !req[0];
    end
`else
    always_comb begin
        pick_req     = req;
        win_vld      = rr_found;
        win_idx      = rr_idx;
        win_upd_last = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_in       <= '0;
            ack         <= '0;
            grant_id    <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= LAST_RST;
            start_cnt   <= '0;
        end else begin
            ack         <= '0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!tx_busy && win_vld) begin
                        tx_in     <= req_bytes[win_idx];
                        grant_id  <= win_idx;
                        tx_start  <= 1'b1;
                        arb_busy  <= 1'b1;
                        start_cnt <= '0;
                        state     <= START;
                        if (win_upd_last) begin
                            last_grant <= win_idx;
                        end
                    end
                end
                START: begin
                    // tx_busy wins over the timeout on the final count.
                    if (tx_busy) begin
                        tx_start      <= 1'b0;
                        ack[grant_id] <= 1'b1;
                        state         <= SEND;
                    end else if (start_cnt == CNT_LAST) begin
                        tx_start    <= 1'b0;
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        start_cnt <= start_cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scripted transmitter model,
// transaction-level arbitration model, randomized frames.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;
    logic [7:0]     tx_in;
    logic           tx_start;
    logic           tx_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int last_g;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err),
        .tx_in       (tx_in),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Winner by the arbitration rule: first requester after the last winner.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
`ifdef UART_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] all_outs;
        return 32'({ack, grant_id, arb_busy, timeout_err, tx_in, tx_start});
    endfunction

    // One frame: grant, optional drop/data change, transmitter delay, busy
    // hold, release. timeout=1 leaves tx_busy low for the whole window.
    task automatic frame(input logic [N-1:0] r, input int delay, input int hold,
                         input bit drop, input bit timeout);
        int         g;
        logic [7:0] exp_b;
        req   = r;
        g     = model_pick(r, last_g);
        exp_b = (g >= 0) ? req_data[8*g +: 8] : 8'h00;
        tick;
        if (g < 0) begin
            chk("nogrant_busy", 32'(arb_busy), 0);
            chk("nogrant_start", 32'(tx_start), 0);
            return;
        end
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("grant_byte", 32'(tx_in), 32'(exp_b));
        chk("grant_start", 32'(tx_start), 1);
        chk("grant_busy", 32'(arb_busy), 1);
`ifdef UART_ARB_PRIO0_EN
        if (g != 0) last_g = g;
`else
        last_g = g;
`endif
        if (drop) begin
            req[g] = 1'b0;
            req_data[8*g +: 8] = 8'hFF;
        end
        if (timeout) begin
            for (int c = 0; c < TO; c++) begin
                tick;
                if (c < TO - 1) begin
                    chk("to_start_held", 32'(tx_start), 1);
                    chk("to_no_err_yet", 32'(timeout_err), 0);
                end
            end
            chk("to_err", 32'(timeout_err), 1);
            chk("to_start_drop", 32'(tx_start), 0);
            chk("to_no_ack", 32'(ack), 0);
            chk("to_idle", 32'(arb_busy), 0);
            req = '0;
            tick;
            chk("to_err_pulse", 32'(timeout_err), 0);
            return;
        end
        repeat (delay) begin
            tick;
            chk("start_held", 32'(tx_start), 1);
            chk("start_no_ack", 32'(ack), 0);
        end
        tx_busy = 1'b1;
        tick;
        chk("ack", 32'(ack), 32'(1 << g));
        chk("ack_start_low", 32'(tx_start), 0);
        chk("ack_no_err", 32'(timeout_err), 0);
        for (int h = 1; h < hold; h++) begin
            tick;
            chk("send_no_ack", 32'(ack), 0);
            chk("send_byte", 32'(tx_in), 32'(exp_b));
            chk("send_busy", 32'(arb_busy), 1);
        end
        tx_busy = 1'b0;
        tick;
        chk("release_idle", 32'(arb_busy), 0);
        chk("release_no_ack", 32'(ack), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        last_g   = N - 1;
        repeat (2) tick;
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick;
        chk("post_reset_idle", all_outs(), 0);

        // Single requester, slow transmitter.
        req_data[7:0] = 8'hA5;
        frame(4'b0001, 3, 160, 1'b0, 1'b0);

        // Fairness with all four held.
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int i = 0; i < 5; i++) begin
            frame(4'b1111, $urandom_range(0, 6), $urandom_range(1, 10), 1'b0, 1'b0);
        end

        // Transmitter busy in IDLE: no grant.
        req     = 4'b0001;
        tx_busy = 1'b1;
        tick;
        chk("busy_idle_nogrant", 32'(arb_busy), 0);
        chk("busy_idle_nostart", 32'(tx_start), 0);
        tx_busy = 1'b0;

        // Timeout, then the next grant rotates past the timed-out requester.
        frame(4'b0100, 0, 0, 1'b0, 1'b1);
        frame(4'b1011, 2, 3, 1'b0, 1'b0);

        // Drop and data change during START; no regrant afterwards.
        req_data[15:8] = 8'h5C;
        frame(4'b0010, 2, 5, 1'b1, 1'b0);
        frame(req, 0, 1, 1'b0, 1'b0);

        // tx_busy arrives on the final count: accepted, no error.
        req_data = 32'($urandom);
        frame(4'b1000, TO - 1, 4, 1'b0, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 30; i++) begin
            req_data = 32'($urandom);
            frame(4'($urandom_range(0, 15)), $urandom_range(0, TO - 1),
                  $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
        end

        // Reset in SEND.
        req_data = 32'($urandom);
        req      = 4'b0100;
        tick;
        tx_busy  = 1'b1;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        tx_busy = 1'b0;
        req     = '0;
        tick;
        rst_n  = 1'b1;
        last_g = N - 1;
        frame(4'b1010, 1, 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
